ext_pipe_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate extender.
- Performs immediate extension (sign, zero, sign-shift, load-upper) and load-data extraction/extension (byte or half, signed or unsigned, selected by byte offset).
- Result is registered behind a valid/ready handshake with a 2-entry skid buffer, so it sits between pipeline stages (ID→EX for immediates, MEM→WB for loads) and supports stall and flush.

---
 rtl/ext_pkg.sv | 21 ++
 rtl/ext_core.sv | 59 +++++
 rtl/ext_pipe_unit.sv | 122 ++++++++++++
 tb/tb_ext_pipe_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the extension pipeline unit.
//   - Mode codes for ext_core / ext_pipe_unit (3-bit mode input).
//   - Skid-buffer occupancy states.
package ext_pkg;

  localparam logic [2:0] EXT_SIGN     = 3'd0;
  localparam logic [2:0] EXT_ZERO     = 3'd1;
  localparam logic [2:0] EXT_SIGN_SHL = 3'd2;
  localparam logic [2:0] EXT_UPPER    = 3'd3;
  localparam logic [2:0] EXT_LB       = 3'd4;
  localparam logic [2:0] EXT_LBU      = 3'd5;
  localparam logic [2:0] EXT_LH       = 3'd6;
  localparam logic [2:0] EXT_LHU      = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate / load-data extender.
// Optional feature macro: EXT_ERR_EN (flag misaligned halfword loads).
// Ports:
//   mode    - operation select (ext_pkg codes)
//   data_in - immediate in the low IN_W bits, or the full load word
//   offset  - byte offset for load modes
//   result  - extended value
//   err     - misaligned halfword (always 0 unless EXT_ERR_EN)
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHL_AMT = 2,
  parameter int unsigned OFF_W   = 2
) (
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] data_in,
  input  logic [OFF_W-1:0] offset,
  output logic [OUT_W-1:0] result,
  output logic             err
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  logic [IN_W-1:0]  imm;
  logic [OUT_W-1:0] imm_sext;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  assign imm      = data_in[IN_W-1:0];
  assign imm_sext = {{EXT_W{imm[IN_W-1]}}, imm};
  // Little-endian lane select; halfword lane ignores offset[0].
  assign sel_byte = data_in[{offset, 3'b000} +: 8];
  assign sel_half = data_in[{offset[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (mode)
      EXT_SIGN:     result = imm_sext;
      EXT_ZERO:     result = {{EXT_W{1'b0}}, imm};
      EXT_SIGN_SHL: result = imm_sext << SHL_AMT;
      EXT_UPPER:    result = {imm, {EXT_W{1'b0}}};
      EXT_LB:       result = {{(OUT_W-8){sel_byte[7]}}, sel_byte};
      EXT_LBU:      result = {{(OUT_W-8){1'b0}}, sel_byte};
      EXT_LH:       result = {{(OUT_W-16){sel_half[15]}}, sel_half};
      EXT_LHU:      result = {{(OUT_W-16){1'b0}}, sel_half};
      default:      result = '0;
    endcase
`ifdef EXT_ERR_EN
    if ((mode == EXT_LH || mode == EXT_LHU) && offset[0]) begin
      result = '0;
      err    = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/ext_pipe_unit.sv
// Pipelined extender: ext_core followed by an output register and one skid
// register behind a valid/ready handshake (1-cycle latency, full throughput).
// Optional feature macro: EXT_ERR_EN (passed through to ext_core).
// Ports:
//   clk, reset (sync, active-low), flush (sync clear of buffered beats)
//   in_valid/in_ready, mode, data_in, offset  - input beat
//   out_valid/out_ready, data_out, err        - output beat
module ext_pipe_unit
  import ext_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHL_AMT = 2,
  parameter int unsigned OFF_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] data_in,
  input  logic [OFF_W-1:0] offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             err
);

  ext_state_e       state_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [OUT_W-1:0] data_q;
  logic             err_q;
  logic [OUT_W-1:0] skid_data_q;
  logic             skid_err_q;

  logic [OUT_W-1:0] core_data;
  logic             core_err;
  logic             accept;
  logic             drain;

  ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHL_AMT (SHL_AMT),
    .OFF_W   (OFF_W)
  ) u_core (
    .mode    (mode),
    .data_in (data_in),
    .offset  (offset),
    .result  (core_data),
    .err     (core_err)
  );

  // in_ready_q is a pure state bit, so accept never depends on out_ready.
  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            data_q      <= core_data;
            err_q       <= core_err;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          in_ready_q <= 1'b1;
          if (accept && drain) begin
            data_q <= core_data;
            err_q  <= core_err;
          end else if (accept) begin
            // Output stalled: park the new beat and stop accepting.
            skid_data_q <= core_data;
            skid_err_q  <= core_err;
            state_q     <= ST_TWO;
            in_ready_q  <= 1'b0;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            data_q     <= skid_data_q;
            err_q      <= skid_err_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Self-checking bench for ext_pipe_unit: a queue-based reference model plus
// directed vectors with literal expectations.
module tb_ext_pipe_unit;

  localparam int unsigned OUT_W = 32;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, err;
  logic [2:0]  mode;
  logic [31:0] data_in, data_out;
  logic [1:0]  offset;

  int n_vec = 0;
  int n_err = 0;
  bit en = 1'b0;

  ext_pipe_unit #(
    .IN_W    (16),
    .OUT_W   (OUT_W),
    .SHL_AMT (2),
    .OFF_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .data_in   (data_in),
    .offset    (offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference extension straight from the mode definitions, in plain arithmetic.
  function automatic logic [32:0] ext_model(input logic [2:0] m, input logic [31:0] d,
                                            input logic [1:0] o);
    longint u16 = longint'(d) & 65535;
    longint s16 = (u16 >= 32768) ? u16 - 65536 : u16;
    longint b   = (longint'(d) >> (8 * int'(o))) & 255;
    longint sb  = (b >= 128) ? b - 256 : b;
    longint h   = (longint'(d) >> (16 * (int'(o) / 2))) & 65535;
    longint sh  = (h >= 32768) ? h - 65536 : h;
    longint r;
    logic   e = 1'b0;
    case (m)
      3'd0: r = s16;
      3'd1: r = u16;
      3'd2: r = s16 * 4;
      3'd3: r = u16 * 65536;
      3'd4: r = sb;
      3'd5: r = b;
      3'd6: r = sh;
      default: r = h;
    endcase
`ifdef EXT_ERR_EN
    if (m >= 3'd6 && o[0]) begin
      r = 0;
      e = 1'b1;
    end
`endif
    return {e, r[31:0]};
  endfunction

  // Model: FIFO of at most two results; in_ready whenever it holds fewer than two.
  logic [32:0] mq[$];
  bit m_ok  = 1'b0;
  bit m_rst = 1'b0;

  always @(posedge clk) begin
    bit acc, drn;
    if (!reset) begin
      mq.delete();
      m_ok  = 1'b0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        acc = in_valid && m_ok && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(ext_model(mode, data_in, offset));
      end
      m_ok = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ok && (mq.size() < 2)});
      if (mq.size() > 0) begin
        check("data_out", data_out, mq[0][31:0]);
        check("err", {31'd0, err}, {31'd0, mq[0][32]});
      end
      if (m_rst) begin
        check("rst_data", data_out, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
      end
    end
  end

  // Offer a beat (called at a negedge) and return at the negedge after acceptance.
  task automatic send(input logic [2:0] m, input logic [31:0] d, input logic [1:0] o);
    bit ok;
    bit done = 1'b0;
    mode = m; data_in = d; offset = o; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got not accepted expected accepted");
    end
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [31:0] d;
    logic [1:0]  o;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9] = '{
    '{3'd0, 32'h0000_8000, 2'd0, 32'hFFFF_8000},
    '{3'd1, 32'h0000_8000, 2'd0, 32'h0000_8000},
    '{3'd2, 32'h0000_FFFF, 2'd0, 32'hFFFF_FFFC},
    '{3'd3, 32'h0000_1234, 2'd0, 32'h1234_0000},
    '{3'd4, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80},
    '{3'd5, 32'h80FF_7F01, 2'd3, 32'h0000_0080},
    '{3'd4, 32'h80FF_7F01, 2'd0, 32'h0000_0001},
    '{3'd6, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF},
    '{3'd7, 32'h80FF_7F01, 2'd2, 32'h0000_80FF}
  };

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = 3'd0; data_in = '0; offset = '0;
    @(posedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'h0);
    check("reset_out_valid", {31'd0, out_valid}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'h1);

    // Back-to-back immediates then loads, each result one cycle after its beat.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].m, vecs[i].d, vecs[i].o);
      check("b2b_valid", {31'd0, out_valid}, 32'h1);
      check("b2b_data", data_out, vecs[i].exp);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drained", {31'd0, out_valid}, 32'h0);

    // Backpressure: A, B accepted, C held until the output drains.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_000A, 2'd0);
    send(3'd1, 32'h0000_000B, 2'd0);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'h0);
    mode = 3'd1; data_in = 32'h0000_000C; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_ready", {31'd0, in_ready}, 32'h0);
      check("bp_hold_data", data_out, 32'h0000_000A);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", data_out, 32'h0000_000B);
    check("bp_ready_back", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    check("bp_third", data_out, 32'h0000_000C);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'h0);

    // Flush with two buffered beats and a beat offered.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0011, 2'd0);
    send(3'd1, 32'h0000_0022, 2'd0);
    data_in = 32'h0000_0033; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_valid", {31'd0, out_valid}, 32'h0);
    check("flush2_ready", {31'd0, in_ready}, 32'h1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Flush with one buffered beat while a beat is accepted in the same cycle.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0044, 2'd0);
    data_in = 32'h0000_0055; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", {31'd0, out_valid}, 32'h0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Mid-stream reset with two buffered beats.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0066, 2'd0);
    send(3'd1, 32'h0000_0077, 2'd0);
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'h0);
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_back", {31'd0, in_ready}, 32'h1);
    check("mid_rst_no_beats", {31'd0, out_valid}, 32'h0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Misaligned halfword.
    send(3'd6, 32'h80FF_7F01, 2'd1);
`ifdef EXT_ERR_EN
    check("lh_off1_err", {31'd0, err}, 32'h1);
    check("lh_off1_data", data_out, 32'h0);
`else
    check("lh_off1_err", {31'd0, err}, 32'h0);
    check("lh_off1_data", data_out, 32'h0000_7F01);
`endif
    send(3'd6, 32'h80FF_7F01, 2'd0);
    check("lh_off0_err", {31'd0, err}, 32'h0);
    check("lh_off0_data", data_out, 32'h0000_7F01);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
